// File: rtl/syscon_ctrl_if.sv
// Single-beat classic Wishbone slave port of the system controller.
// Signal names keep the _i/_o suffixes seen from the slave side.
interface syscon_ctrl_if;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/syscon_ctrl.sv
// System controller: clock-lock monitor, uptime counter, scratch register
// and a software-triggered reset pulse with a post-reset guard window.
module syscon_ctrl #(
    parameter int unsigned SOFT_RST_GUARD = 16
) (
    input  logic          wb_clk_o,
    input  logic          rst_pad_i,
    input  logic          locked,
    syscon_ctrl_if.slave  wb,
    output logic          soft_rst_o,
    output logic          irq_o
);

    // Counter wide enough for both LEN (0..255) and the guard reload value.
    localparam int unsigned CW = (SOFT_RST_GUARD > 256) ? $clog2(SOFT_RST_GUARD) : 8;

    typedef enum logic [1:0] {IDLE, ASSERT, GUARD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic        lock_m, lock_s, lock_q;
    logic        lost;
    logic [7:0]  loss_cnt;
    logic [31:0] uptime;
    logic        irq_en;
    logic [7:0]  len;
    logic [31:0] scratch;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;

    logic       loss;
    logic       acc;
    logic       wr_status, wr_control, wr_uptime, wr_scratch;
    logic       start;
    logic [7:0] len_new;

    // A 1->0 on the synchronized lock; lock_q resets to 0 so a reset-time rise is not a loss.
    assign loss = lock_q & ~lock_s;

    // Accept a request only while ack is low, which forces a gap between acks.
    assign acc        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr_status  = acc & wb.wb_we_i & (wb.wb_adr_i[3:2] == 2'd0);
    assign wr_control = acc & wb.wb_we_i & (wb.wb_adr_i[3:2] == 2'd1);
    assign wr_uptime  = acc & wb.wb_we_i & (wb.wb_adr_i[3:2] == 2'd2);
    assign wr_scratch = acc & wb.wb_we_i & (wb.wb_adr_i[3:2] == 2'd3);

    assign len_new = wb.wb_sel_i[1] ? wb.wb_dat_i[15:8] : len;
    assign start   = wr_control & wb.wb_sel_i[0] & wb.wb_dat_i[1] & (state == IDLE);

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

    always_comb begin
        rdata = '0;
        case (wb.wb_adr_i[3:2])
            2'd0: rdata = {16'h0000, loss_cnt, 5'b00000, (state != IDLE), lost, lock_s};
            2'd1: rdata = {16'h0000, len, 7'b0000000, irq_en};
            2'd2: rdata = uptime;
            default: rdata = scratch;
        endcase
    end

    always_ff @(posedge wb_clk_o or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            lock_m   <= 1'b0;
            lock_s   <= 1'b0;
            lock_q   <= 1'b0;
            lost     <= 1'b0;
            loss_cnt <= '0;
            uptime   <= '0;
            irq_o    <= 1'b0;
        end else begin
            lock_m <= locked;
            lock_s <= lock_m;
            lock_q <= lock_s;
            if (loss)
                lost <= 1'b1;
            else if (wr_status && wb.wb_sel_i[0] && wb.wb_dat_i[1])
                lost <= 1'b0;
            if (loss && loss_cnt != 8'hFF)
                loss_cnt <= loss_cnt + 8'd1;
            if (wr_uptime)
                uptime <= '0;
            else if (lock_s)
                uptime <= uptime + 32'd1;
            irq_o <= irq_en & lost;
        end
    end

    always_ff @(posedge wb_clk_o or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            irq_en  <= 1'b0;
            len     <= '0;
            scratch <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= acc ? rdata : '0;
            if (wr_control) begin
                if (wb.wb_sel_i[0]) irq_en <= wb.wb_dat_i[0];
                if (wb.wb_sel_i[1]) len    <= wb.wb_dat_i[15:8];
            end
            if (wr_scratch) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (wb.wb_sel_i[i]) scratch[8*i +: 8] <= wb.wb_dat_i[8*i +: 8];
            end
        end
    end

    // ASSERT is held for cnt+1 cycles, so loading LEN yields an LEN+1 pulse.
    always_ff @(posedge wb_clk_o or posedge rst_pad_i) begin
        if (rst_pad_i) begin
            state      <= IDLE;
            cnt        <= '0;
            soft_rst_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ASSERT;
                        cnt        <= CW'(len_new);
                        soft_rst_o <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt == '0) begin
                        state      <= GUARD;
                        cnt        <= CW'(SOFT_RST_GUARD - 1);
                        soft_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    soft_rst_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
